// File: rtl/ht_res_collector.sv
// rtl/ht_res_collector.sv - hash-table result collector: FWFT result FIFO plus per-rescode statistics
package ht_pkg;

   typedef enum logic [1:0] {
      OP_INIT   = 2'd0,
      OP_SEARCH = 2'd1,
      OP_INSERT = 2'd2,
      OP_DELETE = 2'd3
   } ht_opcode_t;

   typedef enum logic [2:0] {
      SEARCH_FOUND                     = 3'd0,
      SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
      INSERT_SUCCESS                   = 3'd2,
      INSERT_SUCCESS_SAME_KEY          = 3'd3,
      INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
      DELETE_SUCCESS                   = 3'd5,
      DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6
   } rescode_t;

   typedef struct packed {
      ht_opcode_t  opcode;
      logic [15:0] key;
      logic [15:0] value;
      rescode_t    rescode;
      logic [7:0]  bucket;
      logic [15:0] found_value;
   } ht_result_t;

endpackage

module ht_res_collector
   import ht_pkg::*;
#(
   parameter int FIFO_AWIDTH = 4,
   parameter int AFULL_LVL   = 12,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  ht_result_t             result_i,
   input  logic                   result_valid_i,
   output logic                   result_ready_o,
   output ht_result_t             out_result_o,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [FIFO_AWIDTH:0]   fill_o,
   output logic                   res_afull_o,
   input  logic [2:0]             cnt_sel_i,
   output logic [CNT_WIDTH-1:0]   cnt_o,
   input  logic                   cnt_clr_i
);

   localparam int                   DEPTH   = 2 ** FIFO_AWIDTH;
   localparam logic [FIFO_AWIDTH:0] DEPTH_F = (FIFO_AWIDTH + 1)'(DEPTH);
   localparam logic [FIFO_AWIDTH:0] AFULL_F = (FIFO_AWIDTH + 1)'(AFULL_LVL);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   ht_result_t             mem_q [DEPTH];
   ht_result_t             mem_d [DEPTH];
   logic [FIFO_AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AWIDTH:0]   fill_q, fill_d;
   logic [CNT_WIDTH-1:0]   cnt_q [8];
   logic [CNT_WIDTH-1:0]   cnt_d [8];
   logic [CNT_WIDTH-1:0]   cnt_o_q, cnt_o_d;
   logic                   push, pop;
   logic [2:0]             res_idx;

   // Handshakes depend only on registered fill, so a pop never frees room for a same-cycle push
   always_comb begin
      result_ready_o = !rst_i && (fill_q < DEPTH_F);
      out_valid_o    = (fill_q != '0);
      push           = result_valid_i && result_ready_o;
      pop            = out_valid_o && out_ready_i;
      res_idx        = result_i.rescode;
   end

   assign out_result_o = mem_q[rd_ptr_q];
   assign fill_o       = fill_q;
   assign res_afull_o  = (fill_q >= AFULL_F);
   assign cnt_o        = cnt_o_q;

   // FIFO next state: storage write, pointer advance with natural wrap, occupancy tracking
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (push) begin
         mem_d[wr_ptr_q] = result_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + 1'b1;
         2'b01:   fill_d = fill_q - 1'b1;
         default: fill_d = fill_q;
      endcase
   end

   // Statistics next state: clear wins over history but never swallows a same-cycle event
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = cnt_clr_i ? '0 : cnt_q[i];
      end
      if (push) begin
         if (cnt_clr_i) begin
            cnt_d[res_idx] = CNT_WIDTH'(1);
         end else if (cnt_q[res_idx] != CNT_MAX) begin
            cnt_d[res_idx] = cnt_q[res_idx] + 1'b1;
         end
      end
      cnt_o_d = cnt_q[cnt_sel_i];
   end

   // Control and statistics registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         cnt_o_q  <= '0;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         cnt_o_q  <= cnt_o_d;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Result storage needs no reset: entries are only read while fill says they are valid
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule
